cska_pipe: RTL and testbench

CSKA_PIPE -- requirements
Module: cska_pipe

---
 rtl/cska_pipe.sv | 126 ++++++++++++
 tb/tb_cska_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor: the WIDTH-bit datapath is cut into STAGES
// slices, one per pipeline stage, with the carry handed forward through a register.
module cska_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int NBLK = SW / BLOCK;

  if ((WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_params
    $error("cska_pipe: WIDTH must be a multiple of STAGES*BLOCK");
  end

  // Returns {carry into slice MSB, slice carry-out, slice sum}.
  function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic          ci);
    logic [SW-1:0] s;
    logic c, rc, cm, p;
    int   idx;
    s  = '0;
    c  = ci;
    cm = ci;
    for (int blk = 0; blk < NBLK; blk++) begin
      rc = c;
      p  = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        idx    = blk * BLOCK + i;
        cm     = rc;
        s[idx] = a[idx] ^ b[idx] ^ rc;
        rc     = (a[idx] & b[idx]) | (rc & (a[idx] ^ b[idx]));
        p      = p & (a[idx] ^ b[idx]);
      end
      c = p ? c : rc;
    end
    return {cm, c, s};
  endfunction

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [STAGES-1:0] cy_q, ov_q, vld_q;

  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [STAGES-1:0] cy_d, ov_d, vld_d;

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [STAGES-1:0] src_c, src_v;
  logic [SW+1:0]     res  [STAGES];

  logic advance;
  logic unused_ok;

  assign advance   = !vld_q[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign Sum       = sum_q[STAGES-1];
  assign Cout      = cy_q[STAGES-1];
  assign Ovf       = ov_q[STAGES-1];
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

  always_comb begin
    // Stage 0 sources come from the ports; subtraction folds into B' and carry-in.
    src_a[0] = A;
    src_b[0] = B ^ {WIDTH{Sub}};
    src_s[0] = '0;
    src_c[0] = Sub | Cin;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = cy_q[k-1];
      src_v[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res[k]   = slice_add(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
      a_d[k]   = src_a[k];
      b_d[k]   = src_b[k];
      sum_d[k] = src_s[k];
      sum_d[k][k*SW +: SW] = res[k][SW-1:0];
      cy_d[k]  = res[k][SW];
      ov_d[k]  = (k == STAGES - 1) ? (res[k][SW+1] ^ res[k][SW]) : 1'b0;
      vld_d[k] = src_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q             <= '0;
      sum_q[STAGES-1]   <= '0;
      cy_q[STAGES-1]    <= 1'b0;
      ov_q[STAGES-1]    <= 1'b0;
    end else if (advance) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ov_q  <= ov_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cska_pipe.sv
// Scoreboard bench for cska_pipe: directed cases on the 32/4/2 build, random
// traffic with random back-pressure on the 16/2/4 and 64/8/1 builds.
module tb_cska_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: (A + B' + c0) mod 2^(w+1); overflow from operand/result signs.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, am, bp, s;
    logic [64:0] full;
    logic co, ov;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bp   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bp} + {64'd0, sub | cin};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
    return {co, ov, s};
  endfunction

  // DUT0: default 32/4/2
  logic in_valid0 = 0, in_ready0, cin0 = 0, sub0 = 0, out_valid0, out_ready0 = 0, cout0, ovf0;
  logic [31:0] a0 = '0, b0 = '0, sum0;
  logic [65:0] q0 [$];

  cska_pipe dut0 (.clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
                  .A(a0), .B(b0), .Cin(cin0), .Sub(sub0), .out_valid(out_valid0),
                  .out_ready(out_ready0), .Sum(sum0), .Cout(cout0), .Ovf(ovf0));

  // DUT1: 16/2/4
  logic in_valid1 = 0, in_ready1, cin1 = 0, sub1 = 0, out_valid1, out_ready1 = 1, cout1, ovf1;
  logic [15:0] a1 = '0, b1 = '0, sum1;
  logic [65:0] q1 [$];

  cska_pipe #(.WIDTH(16), .BLOCK(2), .STAGES(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .Cin(cin1), .Sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1));

  // DUT2: 64/8/1
  logic in_valid2 = 0, in_ready2, cin2 = 0, sub2 = 0, out_valid2, out_ready2 = 1, cout2, ovf2;
  logic [63:0] a2 = '0, b2 = '0, sum2;
  logic [65:0] q2 [$];

  cska_pipe #(.WIDTH(64), .BLOCK(8), .STAGES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(a2), .B(b2), .Cin(cin2), .Sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .Sum(sum2), .Cout(cout2), .Ovf(ovf2));

  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      if (q0.size() == 0) check("d0_spurious_out", 66'd1, 66'd0);
      else check("d0_result", {cout0, ovf0, 32'd0, sum0}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("d1_spurious_out", 66'd1, 66'd0);
      else check("d1_result", {cout1, ovf1, 48'd0, sum1}, q1.pop_front());
    end
    if (!rst && in_valid1 && in_ready1)
      q1.push_back(model(16, {48'd0, a1}, {48'd0, b1}, cin1, sub1));
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) check("d2_spurious_out", 66'd1, 66'd0);
      else check("d2_result", {cout2, ovf2, sum2}, q2.pop_front());
    end
    if (!rst && in_valid2 && in_ready2)
      q2.push_back(model(64, a2, b2, cin2, sub2));
  end

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [65:0] exp);
    logic acc;
    acc = 1'b0;
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; in_valid0 = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in_ready0) acc = 1'b1;
    end
    if (acc) q0.push_back(exp);
    else check("d0_accept_timeout", 66'd0, 66'd1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 30 && q0.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("d0_drain", 66'(q0.size()), 66'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 66'(out_valid0), 66'd0);
    check("rst_sum", 66'(sum0), 66'd0);
    check("rst_cout", 66'(cout0), 66'd0);
    check("rst_ovf", 66'(ovf0), 66'd0);
    rst = 1'b0;
    check("post_rst_in_ready", 66'(in_ready0), 66'd1);
    out_ready0 = 1'b1;

    // Latency: single operand set in an empty pipe appears after exactly 2 edges.
    drive0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 64'h0});
    check("lat_edge1_out_valid", 66'(out_valid0), 66'd0);
    @(posedge clk); #1;
    check("lat_edge2_out_valid", 66'(out_valid0), 66'd1);
    drain0();

    drive0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 64'h8000_0000});
    drive0(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFE});
    drive0(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, {1'b0, 1'b0, 64'h9999_9999});
    drive0(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, {1'b1, 1'b0, 64'h0});
    drain0();

    // Back-pressure: fill the pipe with out_ready low, third set waits.
    out_ready0 = 1'b0;
    drive0(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, {1'b0, 1'b0, 64'h3});
    drive0(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFF0});
    fork
      drive0(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 64'h0});
    join_none
    held = sum0;
    check("stall_first_sum", 66'(sum0), 66'h3);
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_in_ready", 66'(in_ready0), 66'd0);
      check("stall_out_valid", 66'(out_valid0), 66'd1);
      check("stall_sum_stable", 66'(sum0), 66'(held));
    end
    out_ready0 = 1'b1;
    wait fork;
    drain0();

    // Reset with two sets in flight: neither may ever emerge.
    a0 = 32'h0000_1111; b0 = 32'h0000_2222; cin0 = 1'b0; sub0 = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    a0 = 32'h0000_3333; b0 = 32'h0000_4444; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid0 = 1'b0;
    check("flush_out_valid", 66'(out_valid0), 66'd0);
    check("flush_in_ready", 66'(in_ready0), 66'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("flush_no_output", 66'(out_valid0), 66'd0);
    end
    drive0(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, {1'b0, 1'b0, 64'h8});
    drain0();

    // Random traffic with random back-pressure on the other two builds.
    for (int n = 0; n < 600; n++) begin
      in_valid1  = ($urandom_range(0, 3) != 0);
      a1         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b1         = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
      cin1       = 1'($urandom);
      sub1       = 1'($urandom);
      out_ready1 = ($urandom_range(0, 2) != 0);
      in_valid2  = ($urandom_range(0, 3) != 0);
      a2         = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      b2         = ($urandom_range(0, 7) == 0) ? 64'h1 : {$urandom, $urandom};
      cin2       = 1'($urandom);
      sub2       = 1'($urandom);
      out_ready2 = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    for (int i = 0; i < 30 && (q1.size() != 0 || q2.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check("d1_drain", 66'(q1.size()), 66'd0);
    check("d2_drain", 66'(q2.size()), 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
